// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one data RAM port
// between the CPU data path (requester 0) and the program/debug loader (requester 1).
module dmem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wen,
    input  logic [31:0] ram_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration happens here
    // ACCESS | RAM port driven with the latched transaction
    // DONE   | owner's done pulse, rdata presented
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    state_t      state;
    logic        owner;
    logic        prio;
    logic [3:0]  lat_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        win;

    // Single requester wins outright; a tie goes to the favoured one.
    always_comb begin
        win = m1_req;
        if (m0_req && m1_req) win = prio;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            prio    <= 1'b0;
            lat_cnt <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
        end else begin
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner   <= win;
                        prio    <= ~win;
                        we_q    <= win ? m1_we    : m0_we;
                        addr_q  <= win ? m1_addr  : m0_addr;
                        wdata_q <= win ? m1_wdata : m0_wdata;
                        lat_cnt <= LAT_INIT;
                        m0_gnt  <= ~win;
                        m1_gnt  <= win;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        rdata_q <= '0;
                        m0_done <= ~owner;
                        m1_done <= owner;
                        state   <= DONE;
                    end else if (lat_cnt == 4'd0) begin
                        rdata_q <= ram_rdata;
                        m0_done <= ~owner;
                        m1_done <= owner;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port is driven only while accessing, so reset clears it with no edge.
    assign ram_addr  = (state == ACCESS) ? addr_q  : '0;
    assign ram_wdata = (state == ACCESS) ? wdata_q : '0;
    assign ram_wen   = (state == ACCESS) && we_q;

    assign m0_rdata = m0_done ? rdata_q : '0;
    assign m1_rdata = m1_done ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised and directed bench for dmem_arbiter: drivers queue expected
// transactions, a negedge monitor checks arbitration, RAM port, timing and data.
module tb_dmem_arbiter;

    localparam int RD_LAT = 3;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_d [2];
    logic        we_d [2];
    logic [31:0] addr_d [2];
    logic [31:0] wdata_d [2];

    logic        m0_gnt, m0_done, m1_gnt, m1_done, ram_wen;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;

    logic [31:0] ram [16] = '{default: '0};
    logic [31:0] ref_mem [16] = '{default: '0};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int w0, w1, wr;

    txn_t pend0 [$];
    txn_t pend1 [$];

    dmem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(req_d[0]), .m0_we(we_d[0]), .m0_addr(addr_d[0]), .m0_wdata(wdata_d[0]),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(req_d[1]), .m1_we(we_d[1]), .m1_addr(addr_d[1]), .m1_wdata(wdata_d[1]),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = ram[ram_addr[5:2]];
    always @(posedge clk) if (ram_wen) ram[ram_addr[5:2]] <= ram_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, wait for its grant (or cancel it), optionally disturb the
    // request lines after the grant; reports how many edges passed without a grant.
    task automatic issue(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int cancel_at,
                         input bit scramble, output int waited);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (p == 0) pend0.push_back(t); else pend1.push_back(t);
        we_d[p] = we; addr_d[p] = a; wdata_d[p] = d; req_d[p] = 1'b1;
        waited = 0;
        forever begin
            tick();
            if ((p == 0) ? m0_gnt : m1_gnt) break;
            waited++;
            if ((cancel_at > 0 && waited >= cancel_at) || waited > 200) begin
                if (waited > 200) chk("gnt_timeout", 32'(waited), 32'd0);
                req_d[p] = 1'b0;
                if (p == 0) void'(pend0.pop_back()); else void'(pend1.pop_back());
                return;
            end
        end
        req_d[p] = 1'b0;
        if (scramble) begin
            addr_d[p] = a ^ 32'h30; wdata_d[p] = ~d; we_d[p] = ~we;
        end
    endtask

    // Monitor / scoreboard.
    logic        s_req0 = 1'b0, s_req1 = 1'b0;
    bit          cur_act = 0;
    txn_t        cur;
    logic        cur_owner;
    logic [31:0] cur_exp;
    int          gnt_cyc, prev_done;
    logic        last_win = 1'b1;
    bit          b2b_chk = 0;
    bit          have_prev = 0;
    logic        w, exp_w;
    bit          in_acc;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        s_req0 <= req_d[0];
        s_req1 <= req_d[1];
    end

    always @(negedge clk) begin
        if (!rstn) begin
            cur_act   = 0;
            last_win  = 1'b1;
            have_prev = 0;
        end else begin
            if (m0_done || m1_done) begin
                chk("done_excl", 32'(m0_done && m1_done), 32'd0);
                if (!cur_act) chk("stray_done", 32'd1, 32'd0);
                else begin
                    chk("done_owner", 32'(m1_done), 32'(cur_owner));
                    chk("done_latency", 32'(cyc - gnt_cyc), cur.we ? 32'd1 : 32'(RD_LAT));
                    chk("done_rdata", m1_done ? m1_rdata : m0_rdata, cur_exp);
                    if (b2b_chk && have_prev)
                        chk("done_spacing", 32'(cyc - prev_done), 32'(RD_LAT + 2));
                    have_prev = b2b_chk;
                    prev_done = cyc;
                    cur_act = 0;
                end
            end else if (cur_act && (cyc - gnt_cyc) > (cur.we ? 1 : RD_LAT)) begin
                chk("done_missing", 32'(cyc - gnt_cyc), 32'd0);
                cur_act = 0;
            end
            if (!m0_done) chk("m0_rdata_idle", m0_rdata, 32'd0);
            if (!m1_done) chk("m1_rdata_idle", m1_rdata, 32'd0);

            if (m0_gnt || m1_gnt) begin
                chk("gnt_excl", 32'(m0_gnt && m1_gnt), 32'd0);
                w = m1_gnt;
                if (!s_req0 && !s_req1) chk("gnt_without_req", 32'd1, 32'd0);
                exp_w = (s_req0 && s_req1) ? ~last_win : s_req1;
                chk("winner", 32'(w), 32'(exp_w));
                last_win = w;
                if (cur_act) chk("gnt_while_busy", 32'd1, 32'd0);
                if ((w ? pend1.size() : pend0.size()) == 0) chk("gnt_unexpected", 32'(w), 32'd2);
                else begin
                    cur = w ? pend1.pop_front() : pend0.pop_front();
                    cur_owner = w;
                    cur_exp = cur.we ? 32'd0 : ref_mem[cur.addr[5:2]];
                    if (cur.we) ref_mem[cur.addr[5:2]] = cur.wdata;
                    cur_act = 1;
                    gnt_cyc = cyc;
                end
            end

            in_acc = cur_act && ((cyc - gnt_cyc) < (cur.we ? 1 : RD_LAT));
            chk("ram_addr", ram_addr, in_acc ? cur.addr : 32'd0);
            chk("ram_wdata", ram_wdata, in_acc ? cur.wdata : 32'd0);
            chk("ram_wen", 32'(ram_wen), 32'(in_acc && cur.we));
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
        chk({nm, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
        chk({nm, "_m0_done"}, 32'(m0_done), 32'd0);
        chk({nm, "_m1_done"}, 32'(m1_done), 32'd0);
        chk({nm, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({nm, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({nm, "_ram_addr"}, ram_addr, 32'd0);
        chk({nm, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({nm, "_ram_wen"}, 32'(ram_wen), 32'd0);
    endtask

    task automatic drain();
        repeat (RD_LAT + 4) tick();
        chk("drain_idle", 32'(cur_act), 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [3:0] idx;
        idx = 4'($urandom_range(0, 15));
        return {26'd0, idx, 2'b00};
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 1'b0; we_d[i] = 1'b0; addr_d[i] = '0; wdata_d[i] = '0;
        end
        #1 rstn = 1'b0;
        #1 check_zero("reset");

        // Contention: both requesters high out of reset, two transactions each.
        fork
            begin
                issue(0, 1'b1, 32'h4, 32'h1111_0000, 0, 0, w0);
                issue(0, 1'b0, 32'h4, 32'h0, 0, 0, w0);
            end
            begin
                issue(1, 1'b0, 32'h4, 32'h0, 0, 0, w1);
                issue(1, 1'b1, 32'h8, 32'h2222_0000, 0, 0, w1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        drain();

        // Single write then single read of the same word.
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, wr);
        chk("write_gnt_delay", 32'(wr), 32'd0);
        drain();
        issue(1, 1'b0, 32'h10, 32'h0, 0, 0, wr);
        chk("read_gnt_delay", 32'(wr), 32'd0);
        drain();

        // m1 cancels while m0's write is in flight; m0 disturbs its lines after gnt.
        issue(0, 1'b1, 32'h10, 32'hCAFE_F00D, 0, 1, wr);
        issue(1, 1'b0, 32'h20, 32'h0, 2, 0, wr);
        drain();

        // Reset in the middle of a read.
        issue(0, 1'b0, 32'h10, 32'h0, 0, 0, wr);
        tick();
        #2 rstn = 1'b0;
        #1 check_zero("midread_reset");
        tick();
        rstn = 1'b1;
        issue(1, 1'b1, 32'h14, 32'h5A5A_A5A5, 0, 0, wr);
        chk("gnt_after_reset", 32'(wr), 32'd0);
        drain();

        // Back-to-back reads from one requester.
        b2b_chk = 1;
        repeat (4) issue(0, 1'b0, rnd_addr(), 32'h0, 0, 0, wr);
        drain();
        b2b_chk = 0;

        // Random traffic from both requesters.
        fork
            repeat (30) begin
                repeat ($urandom_range(0, 3)) tick();
                issue(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0,
                      1'($urandom_range(0, 1)), w0);
            end
            repeat (30) begin
                repeat ($urandom_range(0, 3)) tick();
                issue(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0,
                      1'($urandom_range(0, 1)), w1);
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single data RAM port (`data_ram_addr` / `data_ram_wdata` / `data_ram_wen` / `data_ram_rdata`) of the `mycpu` top level. It shares that port between requester 0 (the CPU data path) and requester 1 (the program/debug loader). Each transaction is sequenced through a fixed-latency access. Arbitration is round-robin, and every transaction ends with a one-cycle `done` pulse that the requester uses to release its stall.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles the RAM address is held before `ram_rdata` is sampled. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `m0_req`  in  1  requester 0 transaction request.
- `m0_we`  in  1  requester 0 write enable (1 = write, 0 = read).
- `m0_addr`  in  32  requester 0 byte address.
- `m0_wdata`  in  32  requester 0 write data.
- `m0_gnt`  out  1  one-cycle pulse; requester 0 transaction accepted.
- `m0_done`  out  1  one-cycle pulse; requester 0 transaction complete.
- `m0_rdata`  out  32  read data, valid while `m0_done` = 1.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_done`, `m1_rdata`: requester 1, same widths and meanings as requester 0.
- `ram_addr`  out  32  address to the data RAM.
- `ram_wdata`  out  32  write data to the data RAM.
- `ram_wen`  out  1  data RAM write enable.
- `ram_rdata`  in  32  data RAM read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Registered state: `state`, `owner` (0/1), `prio` (0/1), `lat_cnt` (4 bits), and latched `we`, `addr`, `wdata`, `rdata`.

IDLE:
- No request: stay in IDLE.
- Exactly one `mX_req` = 1: that requester wins.
- Both requests = 1: the requester equal to `prio` wins.
- On a win: latch owner and its `we`/`addr`/`wdata`; set `prio` to the loser's index; load `lat_cnt` = `RD_LAT`-1; go to ACCESS.

ACCESS:
- `ram_addr` = latched addr; `ram_wdata` = latched wdata.
- Write: `ram_wen` = 1 for exactly one cycle, then go to DONE.
- Read: `ram_wen` = 0. When `lat_cnt` = 0, capture `ram_rdata` into the rdata register and go to DONE; otherwise decrement `lat_cnt`.

DONE:
- Owner's `done` = 1 for one cycle.
- Owner's `rdata` = captured value on a read, 0 on a write.
- Return to IDLE.

Other rules:
- Outside ACCESS, `ram_addr`, `ram_wdata` and `ram_wen` are 0.
- `mX_rdata` is 0 whenever `mX_done` = 0.
- Requester contract: hold `req`/`we`/`addr`/`wdata` stable from assertion until `gnt`.
  - Dropping `req` before `gnt` cancels the request.
  - Changes after `gnt` are ignored; the latched transaction always completes.
- The non-owner's request is held pending. It is not granted until the FSM is back in IDLE.

## Timing
- Reset (async, immediate):
  - `state` = IDLE, `prio` = 0 (requester 0 favoured), `lat_cnt` = 0.
  - All outputs 0, including `ram_wen`, with no clock edge needed.
  - A reset during ACCESS aborts the access. No `done` is issued and a pending write is dropped.
- Request sampled in IDLE at edge N:
  - `gnt` is high in cycle N+1.
  - ACCESS occupies cycles N+1 .. N+RD_LAT for a read, or cycle N+1 only for a write.
  - `done` is high in the cycle following the last ACCESS cycle.
- Latency from request edge to `done`:
  - Read: RD_LAT+1 cycles.
  - Write: 2 cycles.
- Throughput: one transaction per RD_LAT+2 cycles (read) or 3 cycles (write), since each transaction also spends one cycle in IDLE.
- `gnt` and `done` are registered outputs and never asserted for both requesters in the same cycle.
- `ram_rdata` is sampled on the rising edge that ends the final ACCESS cycle.

## Test plan
- Reset check: assert `rstn` = 0 mid-read with RD_LAT = 3. All outputs go to 0 asynchronously. After release, `m1_req` alone is granted 1 cycle after sampling, and no stale `done` appears.
- Single write: m0 writes addr 0x10, data 0xDEADBEEF. `m0_gnt` one cycle later; `ram_wen` = 1 with `ram_addr` = 0x10 for exactly 1 cycle; `m0_done` next cycle with `m0_rdata` = 0.
- Single read, RD_LAT = 3: m1 reads 0x10 with the RAM model returning 0xDEADBEEF. `ram_addr` = 0x10 for 3 cycles; `m1_done` with `m1_rdata` = 0xDEADBEEF exactly 4 cycles after the request edge.
- Contention: both requests high from reset. Grant order is m0, m1, m0, m1. `prio` toggles, and there is never a simultaneous `gnt` or `done`.
- Cancel and ignore: m1 drops `req` before `gnt`, so no m1 transaction occurs. m0 changes `addr` to 0x20 after `gnt` of a 0x10 write; RAM still sees 0x10.
- Back-to-back reads by one requester (RD_LAT = 1): `done` every 3 cycles, and `ram_wen` stays 0 throughout.
